srambank_ctrl: RTL and testbench

SRAMBANK_CTRL -- requirements
Module: srambank_ctrl

---
 rtl/srambank_ctrl.sv | 124 ++++++++++++
 tb/tb_srambank_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/srambank_ctrl.sv
// In-order request FIFO in front of NBANK single-word SRAM banks.
// Reads return through a one-deep valid/ready response slot.
module srambank_ctrl #(
  parameter int DATA   = 18,
  parameter int NBANK  = 4,
  parameter int BANK_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [BANK_W-1:0]     i_req_bank,
  input  logic [DATA-1:0]       i_req_wdata,
  output logic [NBANK-1:0]      o_bank_sel,
  output logic                  o_read_en,
  output logic                  o_write_en,
  output logic [DATA-1:0]       o_write_data,
  input  logic [NBANK*DATA-1:0] i_bank_rdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA-1:0]       o_rsp_data,
  output logic                  o_rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 1 + BANK_W + DATA;

  logic [EW-1:0]     fifo_q [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              head_we;
  logic [BANK_W-1:0] head_bank;
  logic [DATA-1:0]   head_wdata;
  logic              head_ok;
  logic              issue;
  logic              rd_issue;
  logic              rsp_valid;
  logic              rsp_err;
  logic [BANK_W-1:0] rsp_bank;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign {head_we, head_bank, head_wdata} = fifo_q[rd_ptr];
  assign head_ok = ({1'b0, head_bank} < (BANK_W+1)'(NBANK));

  // Writes never need the response slot, so only reads can block the head.
  assign issue    = !empty && (head_we || !rsp_valid || i_rsp_ready);
  assign rd_issue = issue && !head_we;
  assign push     = i_req_valid && !full;
  assign pop      = issue;

  assign o_req_ready  = !full;
  assign o_write_data = head_wdata;
  assign o_rsp_valid  = rsp_valid;
  assign o_rsp_err    = rsp_err;

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= {i_req_we, i_req_bank, i_req_wdata};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_bank  <= '0;
    end else begin
      if (rd_issue) begin
        rsp_valid <= 1'b1;
        rsp_err   <= !head_ok;
        rsp_bank  <= head_bank;
      end else if (i_rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    o_bank_sel = '0;
    o_read_en  = 1'b0;
    o_write_en = 1'b0;
    if (issue && head_ok) begin
      o_read_en  = !head_we;
      o_write_en = head_we;
      for (int k = 0; k < NBANK; k++) begin
        o_bank_sel[k] = (head_bank == BANK_W'(k));
      end
    end
  end

  always_comb begin
    o_rsp_data = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (!rsp_err && rsp_bank == BANK_W'(k)) begin
        o_rsp_data = i_bank_rdata[k*DATA +: DATA];
      end
    end
  end

endmodule

// File: tb/tb_srambank_ctrl.sv
// Bench for srambank_ctrl: single-word bank models plus an
// in-order read response scoreboard.
module tb_srambank_ctrl;

  localparam int DATA   = 18;
  localparam int NBANK  = 4;
  localparam int BANK_W = 3;
  localparam int DEPTH  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [BANK_W-1:0]     req_bank;
  logic [DATA-1:0]       req_wdata;
  logic [NBANK-1:0]      bank_sel;
  logic                  read_en;
  logic                  write_en;
  logic [DATA-1:0]       write_data;
  logic [NBANK*DATA-1:0] bank_rdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA-1:0]       rsp_data;
  logic                  rsp_err;

  srambank_ctrl #(
    .DATA(DATA), .NBANK(NBANK), .BANK_W(BANK_W), .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_we(req_we),
    .i_req_bank(req_bank),
    .i_req_wdata(req_wdata),
    .o_bank_sel(bank_sel),
    .o_read_en(read_en),
    .o_write_en(write_en),
    .o_write_data(write_data),
    .i_bank_rdata(bank_rdata),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data),
    .o_rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  logic [DATA-1:0] mem    [NBANK] = '{default: '0};
  logic [DATA-1:0] dout   [NBANK] = '{default: '0};
  logic [DATA-1:0] shadow [8]     = '{default: '0};
  logic [DATA:0]   sb [$];
  int total = 0;
  int bad = 0;
  int run = 0;
  int maxrun = 0;

  for (genvar g = 0; g < NBANK; g++) begin : g_rd
    assign bank_rdata[g*DATA +: DATA] = dout[g];
  end

  // Synchronous single-word banks: output register loads on read strobe.
  always @(posedge clk) begin
    for (int k = 0; k < NBANK; k++) begin
      if (write_en && bank_sel[k]) mem[k] <= write_data;
      if (read_en && bank_sel[k]) dout[k] <= mem[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [DATA:0] e;
    if (rst_n) begin
      chk("excl", {30'b0, read_en && write_en,
                   $countones(bank_sel) > 1}, 32'd0);
      if (rsp_valid) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e[DATA-1:0]));
          chk("rsp_err", 32'(rsp_err), 32'(e[DATA]));
        end
      end
    end
  end

  task automatic send(input logic we, input logic [BANK_W-1:0] bank,
                      input logic [DATA-1:0] d);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_bank  = bank;
    req_wdata = d;
    for (int n = 0; n < 64 && !acc; n++) begin
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    else if (we) begin
      if (int'(bank) < NBANK) shadow[bank] = d;
    end else begin
      sb.push_back(int'(bank) < NBANK ? {1'b0, shadow[bank]}
                                      : {1'b1, DATA'(0)});
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 64) begin
      cyc(1);
      n++;
    end
    chk("drain", sb.size(), 32'd0);
    cyc(1);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 32) begin
      cyc(1);
      n++;
    end
    chk("wait_rsp", 32'(rsp_valid), 32'd1);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_sel"}, 32'(bank_sel), 32'd0);
    chk({tag, "_re"}, 32'(read_en), 32'd0);
    chk({tag, "_we"}, 32'(write_en), 32'd0);
  endtask

  initial begin
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_bank  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    cyc(2);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    idle_chk("rst");
    rst_n = 1'b1;
    cyc(1);
    idle_chk("post_rst");

    send(1'b1, 3'd0, 18'h11111);
    send(1'b1, 3'd1, 18'h0BEEF);
    send(1'b1, 3'd3, 18'h3C3C3);
    cyc(1);

    send(1'b1, 3'd2, 18'h2A5A3);
    chk("wr_en", 32'(write_en), 32'd1);
    chk("wr_sel", 32'(bank_sel), 32'b0100);
    chk("wr_data", 32'(write_data), 32'h2A5A3);
    chk("wr_re", 32'(read_en), 32'd0);
    send(1'b0, 3'd2, '0);
    chk("rd_en", 32'(read_en), 32'd1);
    chk("rd_sel", 32'(bank_sel), 32'b0100);
    chk("rd_we", 32'(write_en), 32'd0);
    cyc(1);
    chk("rd_lat", 32'(rsp_valid), 32'd1);
    cyc(1);
    chk("rd_clr", 32'(rsp_valid), 32'd0);

    send(1'b0, 3'd5, '0);
    idle_chk("oor_rd");
    cyc(1);
    chk("oor_rspv", 32'(rsp_valid), 32'd1);
    chk("oor_err", 32'(rsp_err), 32'd1);
    chk("oor_data", 32'(rsp_data), 32'd0);
    cyc(1);
    send(1'b1, 3'd7, 18'h3FFFF);
    idle_chk("oor_wr");
    send(1'b0, 3'd3, '0);
    chk("after_oor_re", 32'(read_en), 32'd1);
    chk("after_oor_sel", 32'(bank_sel), 32'b1000);
    drain();

    maxrun = 0;
    for (int b = 0; b < NBANK; b++) send(1'b0, BANK_W'(b), '0);
    drain();
    cyc(1);
    chk("b2b_run", maxrun, 32'd4);

    rsp_ready = 1'b0;
    send(1'b0, 3'd1, '0);
    wait_rsp();
    send(1'b1, 3'd3, 18'h15555);
    chk("stall_we", 32'(write_en), 32'd1);
    chk("stall_wsel", 32'(bank_sel), 32'b1000);
    send(1'b0, 3'd3, '0);
    chk("stall_re0", 32'(read_en), 32'd0);
    cyc(3);
    chk("stall_re1", 32'(read_en), 32'd0);
    chk("stall_rspv", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    #1;
    chk("unstall_re", 32'(read_en), 32'd1);
    chk("unstall_sel", 32'(bank_sel), 32'b1000);
    drain();

    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, BANK_W'(i % NBANK), '0);
    chk("full_ready0", 32'(req_ready), 32'd0);
    cyc(2);
    chk("full_ready1", 32'(req_ready), 32'd0);
    chk("full_re", 32'(read_en), 32'd0);
    rsp_ready = 1'b1;
    send(1'b0, 3'd2, '0);
    drain();

    rsp_ready = 1'b0;
    send(1'b0, 3'd5, '0);
    send(1'b0, 3'd0, '0);
    send(1'b0, 3'd1, '0);
    send(1'b0, 3'd2, '0);
    chk("pre_rst_err", 32'(rsp_err), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_rspv", 32'(rsp_valid), 32'd0);
    chk("mid_rst_err", 32'(rsp_err), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    idle_chk("mid_rst");
    cyc(2);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      idle_chk("rel");
      chk("rel_rspv", 32'(rsp_valid), 32'd0);
    end
    send(1'b0, 3'd2, '0);
    chk("rel_rd", 32'(read_en), 32'd1);
    drain();

    chk("sb_left", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
